// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for fifo_write_arbiter.
// Optional statistics counters in the top are enabled by FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;

  localparam int STAT_W   = 32;
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // Candidates are visited farthest-first so the one nearest rr_ptr is written last and wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                       input logic [MAX_ID_W-1:0] rr_ptr,
                                       input int                  num_req);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      if (k < num_req) begin
        idx = 32'(rr_ptr) + 32'(k);
        if (idx >= 32'(num_req)) idx = idx - 32'(num_req);
        if (req[idx[MAX_ID_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = idx[MAX_ID_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational rotate-and-priority-encode: first requester at or after rr_ptr.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    pick
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           res;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    res                  = rr_pick(req_ext, MAX_ID_W'(rr_ptr), NUM_REQ);
    found                = res.found;
    pick                 = res.idx[ID_W-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-producer beat and stall counters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_SIZE = 32,
  parameter  int MAX_BURST = 8,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST+1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_chip_select,
  output logic                         fifo_write_enable,
  output logic [DATA_SIZE-1:0]         fifo_data_in,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]    stat_beats,
  output logic [STAT_W-1:0]            stat_stall_cycles
`endif
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic             in_lock, beat, burst_end;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .pick   (pick_id)
  );

  always_comb begin
    in_lock    = (state_q == ARB_LOCK);
    beat       = in_lock & req[owner_q] & ~fifo_full;
    burst_end  = beat & (req_last[owner_q] | (beat_cnt_q == CNT_W'(MAX_BURST-1)));
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (!in_lock) begin
      // Arbitration cycle never carries a beat: one bubble per grant.
      if (pick_found) begin
        owner_d    = pick_id;
        beat_cnt_d = '0;
        state_d    = ARB_LOCK;
      end
    end else if (burst_end) begin
      state_d    = ARB_IDLE;
      beat_cnt_d = '0;
      rr_ptr_d   = (owner_q == ID_W'(NUM_REQ-1)) ? '0 : owner_q + ID_W'(1);
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    busy              = in_lock;
    fifo_chip_select  = in_lock;
    fifo_write_enable = beat;
    grant_id          = in_lock ? owner_q : '0;
    req_ready         = '0;
    fifo_data_in      = '0;
    if (in_lock) begin
      req_ready[owner_q] = ~fifo_full;
      fifo_data_in       = req_data[owner_q*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_beats_q, stat_beats_d;
  logic [STAT_W-1:0]              stall_q, stall_d;

  // Both counters saturate at all-ones rather than wrap.
  always_comb begin
    stat_beats_d = stat_beats_q;
    stall_d      = stall_q;
    if (beat && (stat_beats_q[owner_q] != '1))
      stat_beats_d[owner_q] = stat_beats_q[owner_q] + STAT_W'(1);
    if (in_lock && req[owner_q] && fifo_full && (stall_q != '1))
      stall_d = stall_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_beats_q <= '0;
      stall_q      <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stall_q      <= stall_d;
    end
  end

  assign stat_beats        = stat_beats_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule
